// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and widths.
package shift_pkg;

  localparam int OPW = 3;

  typedef logic [OPW-1:0] op_t;

  localparam op_t OP_ROL = 3'b000;
  localparam op_t OP_SLL = 3'b001;
  localparam op_t OP_ROR = 3'b010;
  localparam op_t OP_SRL = 3'b011;
  localparam op_t OP_SRA = 3'b100;

endpackage

// File: rtl/shift_stage.sv
// One combinational shifter step: shift/rotate by a fixed DIST when enabled.
// Reserved ops and a cleared enable both pass the data through untouched.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] d,
  input  op_t              op,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Select the shifted/rotated form of d for this stage's fixed distance.
  always_comb begin
    q = d;
    if (en) begin
      case (op)
        OP_ROL:  q = {d[WIDTH-DIST-1:0], d[WIDTH-1:WIDTH-DIST]};
        OP_SLL:  q = d << DIST;
        OP_ROR:  q = {d[DIST-1:0], d[WIDTH-1:DIST]};
        OP_SRL:  q = d >> DIST;
        OP_SRA:  q = $signed(d) >>> DIST;
        default: q = d;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Elastic barrel shifter: one registered stage per shift-count bit, each
// stage k applying a 2^k step. Backpressure propagates combinationally from
// out_ready through the chain, so bubbles compact while the output stalls.
module shift_pipe
  import shift_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] In,
  input  logic [SHW-1:0]   Cnt,
  input  op_t              Op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Out,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [SHW-1:0]            vld_pipe;
  logic [SHW-1:0]            adv;
  logic [SHW-1:0][WIDTH-1:0] data_q;
  logic [SHW-1:0][WIDTH-1:0] nxt;
  logic [SHW-1:0][OPW-1:0]   op_q;
  logic [SHW-1:0][SHW-1:0]   cnt_q;
  logic                      tail_full;

  // Stage k may load unless it and every stage after it are occupied while
  // the consumer stalls; written as a running AND to avoid a bit-level loop.
  always_comb begin
    tail_full = 1'b1;
    adv       = '0;
    for (int k = SHW - 1; k >= 0; k--) begin
      tail_full = tail_full & vld_pipe[k];
      adv[k]    = out_ready | ~tail_full;
    end
  end

  // Per-stage datapath: stage 0 works on the incoming operand, later stages
  // on their predecessor's register using the carried count bit.
  for (genvar g = 0; g < SHW; g++) begin : g_stg
    if (g == 0) begin : g_first
      shift_stage #(.WIDTH(WIDTH), .DIST(1)) u_stg (
        .d  (In),
        .op (Op),
        .en (Cnt[0]),
        .q  (nxt[0])
      );
    end else begin : g_rest
      shift_stage #(.WIDTH(WIDTH), .DIST(1 << g)) u_stg (
        .d  (data_q[g-1]),
        .op (op_q[g-1]),
        .en (cnt_q[g-1][g]),
        .q  (nxt[g])
      );
    end
  end

  // Pipeline registers: payload moves only alongside a valid bit, so held
  // stages (and Out) stay stable while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      data_q   <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
    end else begin
      if (adv[0]) begin
        vld_pipe[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= nxt[0];
          op_q[0]   <= Op;
          cnt_q[0]  <= Cnt;
        end
      end
      for (int k = 1; k < SHW; k++) begin
        if (adv[k]) begin
          vld_pipe[k] <= vld_pipe[k-1];
          if (vld_pipe[k-1]) begin
            data_q[k] <= nxt[k];
            op_q[k]   <= op_q[k-1];
            cnt_q[k]  <= cnt_q[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign Out       = data_q[SHW-1];
  assign out_valid = vld_pipe[SHW-1];

  // Op/count of the last stage and already-consumed count bits are kept for
  // observability but drive no logic.
  logic unused_ok;
  assign unused_ok = ^{op_q[SHW-1], cnt_q};

endmodule

// File: tb/tb_shift_pipe.sv
// Directed + randomized bench for shift_pipe (WIDTH = 16).
module tb_shift_pipe;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] In;
  logic [3:0]  Cnt;
  op_t         Op;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Out;
  logic        out_valid;
  logic        out_ready;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_pop  = 0;
  logic [15:0] cur_exp;
  logic [15:0] exp_q[$];
  logic        thr = 1'b0;

  shift_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .In        (In),
    .Cnt       (Cnt),
    .Op        (Op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Out       (Out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_shift(input logic [15:0] a, input logic [3:0] c, input op_t o);
    logic [31:0] dbl;
    dbl = {a, a};
    case (o)
      OP_ROL:  ref_shift = 16'(dbl >> (16 - c));
      OP_ROR:  ref_shift = 16'(dbl >> c);
      OP_SLL:  ref_shift = a << c;
      OP_SRL:  ref_shift = a >> c;
      OP_SRA:  ref_shift = $signed(a) >>> c;
      default: ref_shift = a;
    endcase
  endfunction

  // Scoreboard: expected results queued on input transfer, checked on output transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) chk("unexpected_out", out_valid, 0);
        else chk("out_data", Out, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  // Random consumer throttling during the random phase.
  always @(posedge clk) begin
    #1;
    if (thr) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [15:0] a, input logic [3:0] c, input op_t o, input logic [15:0] e);
    bit ok;
    In = a; Cnt = c; Op = o; cur_exp = e; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk("in_ready_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  logic [15:0] bp_in [6] = '{16'h1234, 16'h1234, 16'h00FF, 16'hFF00, 16'h8421, 16'h0F0F};
  logic [3:0]  bp_cnt[6] = '{4'd4, 4'd4, 4'd8, 4'd8, 4'd3, 4'd15};
  op_t         bp_op [6] = '{OP_ROL, OP_ROR, OP_SLL, OP_SRL, OP_SRA, OP_ROL};
  logic [15:0] bp_exp[6] = '{16'h2341, 16'h4123, 16'hFF00, 16'h00FF, 16'hF084, 16'h8787};

  initial begin
    int acc, idx, p0;
    logic [15:0] a;
    logic [3:0]  c;
    op_t         o;

    rst = 1'b1; in_valid = 1'b0; In = '0; Cnt = '0; Op = OP_ROL; out_ready = 1'b1; cur_exp = '0;
    tick();
    chk("rst_out", Out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back ops, latency and ordering.
    send(16'h8001, 4'd1, OP_ROL, 16'h0003);
    send(16'h00F0, 4'd4, OP_SLL, 16'h0F00);
    send(16'h0001, 4'd1, OP_ROR, 16'h8000);
    chk("lat_early", out_valid, 0);
    tick(); chk("lat_v0", out_valid, 1); chk("lat_d0", Out, 16'h0003);
    tick(); chk("lat_v1", out_valid, 1); chk("lat_d1", Out, 16'h0F00);
    tick(); chk("lat_v2", out_valid, 1); chk("lat_d2", Out, 16'h8000);
    tick(); chk("lat_after", out_valid, 0);
    drain();

    // Right-shift boundaries.
    send(16'h8000, 4'd15, OP_SRL, 16'h0001);
    send(16'h8000, 4'd15, OP_SRA, 16'hFFFF);
    send(16'h7FF0, 4'd4,  OP_SRA, 16'h07FF);
    drain();

    // Zero count for every op, and reserved ops with a nonzero count.
    for (int k = 0; k < 5; k++) send(16'hA5C3, 4'd0, op_t'(k), 16'hA5C3);
    for (int k = 5; k < 8; k++) send(16'hA5C3, 4'd5, op_t'(k), 16'hA5C3);
    drain();

    // Backpressure: 8 stalled cycles with 6 operands offered.
    out_ready = 1'b0;
    acc = 0; idx = 0;
    In = bp_in[0]; Cnt = bp_cnt[0]; Op = bp_op[0]; cur_exp = bp_exp[0]; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 4) chk("stall_hold", Out, 16'h2341);
      if (in_ready) begin acc++; idx++; end
      tick();
      In = bp_in[idx]; Cnt = bp_cnt[idx]; Op = bp_op[idx]; cur_exp = bp_exp[idx];
    end
    in_valid = 1'b0;
    chk("stall_accepted", acc, 4);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    p0 = n_pop;
    out_ready = 1'b1;
    for (int i = idx; i < 6; i++) send(bp_in[i], bp_cnt[i], bp_op[i], bp_exp[i]);
    drain();
    chk("stall_all_out", n_pop - p0, 6);

    // Reset with three operations in flight; an input offered during reset is dropped.
    send(16'h0001, 4'd1, OP_SLL, 16'h0002);
    send(16'h0002, 4'd1, OP_SLL, 16'h0004);
    send(16'h0004, 4'd1, OP_SLL, 16'h0008);
    rst = 1'b1; In = 16'hDEAD; Cnt = 4'd1; Op = OP_SLL; cur_exp = 16'hBD5A; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_out", Out, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin tick(); chk("no_stale", out_valid, 0); end
    send(16'h1111, 4'd2, OP_ROL, 16'h4444);
    tick(); chk("post_rst_lat1", out_valid, 0);
    tick(); chk("post_rst_lat2", out_valid, 0);
    tick(); chk("post_rst_lat3", out_valid, 1); chk("post_rst_data", Out, 16'h4444);
    drain();

    // Random operations against the reference model with throttled consumer.
    thr = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      a = 16'($urandom);
      c = 4'($urandom_range(0, 15));
      o = op_t'($urandom_range(0, 7));
      send(a, c, o, ref_shift(a, c, o));
    end
    thr = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Pipelined, parametrised barrel shifter that generalises the single-bit shift stage to any power-of-two word width and any shift count in 0..WIDTH-1. It adds arithmetic right shift. It also adds valid/ready handshaking on both sides, so it can sit between the register-read stage and writeback of the CPU datapath, or serve a multi-cycle execute unit. There is one registered stage per shift-count bit. Throughput is one operation per cycle, with full backpressure.

## Interface
- WIDTH, 16, data width; power of two, ≥ 2
- SHW, $clog2(WIDTH), shift-count width and pipeline depth (derived, not overridden)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- In  input  WIDTH  operand
- Cnt  input  SHW  shift amount, 0..WIDTH-1
- Op  input  3  000 rotate left, 001 shift left logical, 010 rotate right, 011 shift right logical, 100 shift right arithmetic, 101–111 reserved
- in_valid  input  1  In/Cnt/Op valid
- in_ready  output  1  shifter can accept this cycle
- Out  output  WIDTH  result
- out_valid  output  1  Out valid
- out_ready  input  1  consumer accepts Out this cycle

## Operation
- Stage k (k = 0..SHW-1) holds a valid bit, data, Op and the remaining count bits.
  - If count bit k is 1, the stage applies a shift or rotate by 2^k according to Op.
  - If count bit k is 0, the data passes unchanged.
- Stage fill rules:
  - Rotate: bits wrap around.
  - Logical shift: vacated bits filled with 0.
  - Arithmetic right shift: vacated bits filled with the current MSB. The MSB is invariant across stages, so it equals In[WIDTH-1].
- Reserved Op values: data passes through unchanged at every stage. No error flag.
- Cnt = 0: Out = In for every Op.
- Elastic pipeline:
  - A stage advances when it is empty or when its successor advances.
  - The last stage advances when out_valid & out_ready.
  - in_ready = ~valid[0] | advance[0]. It is combinational from out_ready through the chain; no registered skid.
- Transfer occurs only on valid & ready. Data, Op and Cnt are captured only on transfer.
- Results leave in acceptance order. No reordering, no drops, no duplicates.
- Out = data register of the last stage. out_valid = valid bit of the last stage.
- Out, Op and count are held stable while out_valid & ~out_ready.

## Timing
- Reset: all valid bits and data registers clear on the first edge with rst = 1.
  - Out = 0, out_valid = 0.
  - in_ready = 1 from the cycle after reset is sampled, and stays 1 while rst is held, since all stages are empty.
- Latency: an operation accepted at edge t appears with out_valid = 1 in the cycle after edge t+SHW-1, i.e. SHW cycles, given no stall. For WIDTH = 16 this is 4 cycles.
- Throughput: one acceptance per cycle while out_ready = 1.
- Capacity: SHW operations in flight.
- With out_ready held low, the pipeline compacts bubbles. in_ready falls only when all SHW stages are valid.
- Same cycle: out_ready = 1 with a full pipe still allows in_valid acceptance (pass-through fill).
- Reset mid-operation: all in-flight operations are discarded. out_valid = 0 in the following cycle. An input presented in the reset cycle is not accepted.
- Cnt or Op values outside a transfer cycle are ignored.

## Structure
- Shared package shift_pkg:
  - Op encodings as localparams: OP_ROL, OP_SLL, OP_ROR, OP_SRL, OP_SRA.
  - Op width constant (3).
- Sub-module shift_stage: a combinational single stage parametrised by WIDTH and DIST (= 2^k). Inputs: data, Op, enable. Output: data.
  - It is the width/distance generalisation of the existing one-bit stage.
  - shift_pipe instantiates SHW copies in a generate loop.
  - shift_pipe holds all registers and handshake logic.

## Test plan
- WIDTH = 16, out_ready = 1; send (0x8001, Cnt 1, ROL), (0x00F0, 4, SLL), (0x0001, 1, ROR) on consecutive cycles -> 0x0003, 0x0F00, 0x8000 on consecutive cycles, the first 4 cycles after acceptance.
- Right shifts of 0x8000 by 15: SRL -> 0x0001, SRA -> 0xFFFF. 0x7FF0 SRA 4 -> 0x07FF.
- Cnt 0 with each Op, and Op 101 with Cnt 5, on 0xA5C3 -> 0xA5C3 in every case.
- out_ready low for 8 cycles while in_valid stays high with 6 distinct operands -> exactly 4 accepted, in_ready = 0 afterwards. Out is held stable. On release, all 6 results emerge in order with none lost.
- rst asserted for 1 cycle with 3 operations in flight -> out_valid = 0 and Out = 0 next cycle. No stale result ever appears. A new operation afterwards completes with 4-cycle latency.
- Random In/Cnt/Op with random out_ready throttling for 10k operations vs. a reference model -> bit-exact, in order.
